// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH CALC cycles plus one FIX cycle for sign correction.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt;
  logic               op_div, neg_q, neg_r;
  logic [WIDTH-1:0]   opnd, acc_hi, acc_lo;
  logic               busy_r, done_r, dz_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  logic             idle_like, accept, b_zero, sgn, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign accept    = start && idle_like;
  assign b_zero    = (b == '0);
  assign sgn       = ~op[0];
  assign sa        = sgn & a[WIDTH-1];
  assign sb        = sgn & b[WIDTH-1];
  assign mag_a     = cond_neg(a, sa);
  assign mag_b     = cond_neg(b, sb);

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  logic signed [WIDTH:0] div_diff;
  logic [WIDTH:0]        mul_sum, div_trial;
  logic                  div_ge;

  assign mul_sum   = {1'b0, acc_hi} + ({1'b0, opnd} & {(WIDTH+1){acc_lo[0]}});
  assign div_trial = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = $signed(div_trial) - $signed({1'b0, opnd});
  assign div_ge    = (div_trial >= {1'b0, opnd});

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign prod   = cond_neg2({acc_hi, acc_lo}, neg_q);
  assign fix_hi = op_div ? cond_neg(acc_hi, neg_r) : prod[2*WIDTH-1:WIDTH];
  assign fix_lo = op_div ? cond_neg(acc_lo, neg_q) : prod[WIDTH-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) nxt = (op[1] && b_zero) ? S_DONE : S_CALC;
        else       nxt = S_IDLE;
      end
      S_CALC:  if (cnt == '0) nxt = S_FIX;
      S_FIX:   nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (nxt == S_CALC) || (nxt == S_FIX);
      done_r <= (nxt == S_DONE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           cnt <= '0;
    else if (accept)                      cnt <= CNT_INIT;
    else if (state == S_CALC && cnt != '0) cnt <= cnt - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      dz_r <= 1'b0;
    else if (accept) dz_r <= op[1] && b_zero;
  end

  // Operands and accumulators carry no reset; they are always loaded on accept
  always_ff @(posedge clock) begin
    if (accept) begin
      op_div <= op[1];
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      acc_hi <= '0;
      acc_lo <= op[1] ? mag_a : mag_b;
      opnd   <= op[1] ? mag_b : mag_a;
    end else if (state == S_CALC) begin
      if (op_div) begin
        acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (state == S_FIX) begin
      hi_r <= fix_hi;
      lo_r <= fix_lo;
    end else if (idle_like && !start) begin
      if (wr_hi) hi_r <= wr_data;
      if (wr_lo) lo_r <= wr_data;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = dz_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expectations come from a plain-arithmetic
// model at issue time; a negedge monitor checks hi/lo/div_zero on every done.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wr_data = '0;
  logic         wr_hi = 1'b0, wr_lo = 1'b0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int           n_pass = 0, n_total = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: signed/unsigned 64-bit arithmetic, SV division truncates toward zero
  function automatic exp_t ref_op(input logic [1:0] o, input logic [W-1:0] x, y,
                                  input logic [W-1:0] ohi, olo);
    exp_t        e;
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    e.dz = 1'b0;
    case (o)
      2'b00: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = ux * uy; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (y == '0) begin
          e.dz = 1'b1; e.hi = ohi; e.lo = olo;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy;
          p = q; e.lo = p[31:0];
          p = r; e.hi = p[31:0];
        end else begin
          p = ux / uy; e.lo = p[31:0];
          p = ux % uy; e.hi = p[31:0];
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected done", 64'(done), 64'(1'b0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result hi", 64'(hi), 64'(e.hi));
        chk("result lo", 64'(lo), 64'(e.lo));
        chk("result div_zero", 64'(div_zero), 64'(e.dz));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, y, input bit push);
    exp_t e;
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (push) begin
      e = ref_op(o, x, y, m_hi, m_lo);
      sb_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) bc++;
      @(posedge clock);
      #1;
      cyc++;
    end
    if (done !== 1'b1) chk("done wait bound", 64'(done), 64'(1'b1));
  endtask

  task automatic write_hl(input bit h, input bit l, input logic [W-1:0] d);
    @(negedge clock);
    wr_hi = h; wr_lo = l; wr_data = d;
    @(posedge clock);
    #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
  endtask

  initial begin
    int cyc, bc;

    repeat (2) @(posedge clock);
    #1;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset div_zero", 64'(div_zero), 64'(0));
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done(cyc, bc);
    chk("mult latency", 64'(cyc), 64'(33));
    chk("mult busy cycles", 64'(bc), 64'(33));
    @(posedge clock);
    #1;
    chk("done single pulse", 64'(done), 64'(0));

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(cyc, bc);
    issue(2'b01, 32'd3, 32'd3, 1'b1);
    wait_done(cyc, bc);
    chk("back-to-back latency", 64'(cyc), 64'(33));

    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(cyc, bc);
    issue(2'b11, 32'd7, 32'd2, 1'b1);
    wait_done(cyc, bc);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(cyc, bc);
    chk("div latency", 64'(cyc), 64'(33));

    write_hl(1'b1, 1'b1, 32'h12);
    write_hl(1'b0, 1'b1, 32'h34);
    chk("wr hi", 64'(hi), 64'(32'h12));
    chk("wr lo", 64'(lo), 64'(32'h34));
    issue(2'b10, 32'd99, 32'd0, 1'b1);
    wait_done(cyc, bc);
    chk("div0 latency", 64'(cyc), 64'(0));
    chk("div0 flag", 64'(div_zero), 64'(1));
    issue(2'b01, 32'd2, 32'd3, 1'b1);
    chk("div0 cleared", 64'(div_zero), 64'(0));
    wait_done(cyc, bc);

    issue(2'b01, 32'd5, 32'd9, 1'b1);
    fork
      wait_done(cyc, bc);
      begin
        repeat (5) @(posedge clock);
        @(negedge clock);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd0;
        wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(negedge clock);
        start = 1'b0; wr_hi = 1'b0;
      end
    join
    chk("ignored start latency", 64'(cyc), 64'(33));

    write_hl(1'b0, 1'b1, 32'hA5A5_A5A5);
    chk("mtlo lo", 64'(lo), 64'(32'hA5A5_A5A5));
    chk("mtlo hi kept", 64'(hi), 64'(m_hi));

    for (int i = 0; i < 30; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      issue(ro, ra, rb, 1'b1);
      wait_done(cyc, bc);
      chk("random latency", 64'(cyc), 64'((ro[1] && rb == '0) ? 0 : 33));
      if ($urandom_range(0, 3) == 0) begin
        write_hl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        chk("random wr hi", 64'(hi), 64'(m_hi));
        chk("random wr lo", 64'(lo), 64'(m_lo));
      end
    end

    issue(2'b01, 32'hFFFF_FFFF, 32'd3, 1'b0);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort hi", 64'(hi), 64'(0));
    chk("abort lo", 64'(lo), 64'(0));
    m_hi = '0;
    m_lo = '0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    issue(2'b01, 32'd6, 32'd7, 1'b1);
    wait_done(cyc, bc);

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard drained", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
